axi4lite_wr_master: RTL

// Parametrised AXI4-Lite write-only master. Accepts write commands (addr/data/strb) on a

---
 rtl/axi4lite_wr_master.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/axi4lite_wr_master.sv
// AXI4-Lite write-only master: one outstanding write at a time. A command is
// accepted in IDLE, AW and W are issued together with independent handshakes,
// the B response (or a timeout) is handed back on a valid/ready response port.
module axi4lite_wr_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    // Command port
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_data_i,
    input  logic [STRB_WIDTH-1:0] cmd_strb_i,

    // Response port
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [1:0]            rsp_resp_o,
    output logic                  rsp_timeout_o,

    // Status
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  wr_cnt_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o,

    // AXI4-Lite write address channel
    output logic [ADDR_WIDTH-1:0] awaddr_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,

    // AXI4-Lite write data channel
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [STRB_WIDTH-1:0] wstrb_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,

    // AXI4-Lite write response channel
    input  logic [1:0]            bresp_i,
    input  logic                  bvalid_i,
    output logic                  bready_o
);

    // Timer only ever needs to reach TIMEOUT_CYCLES-1.
    localparam int unsigned TimerWidth = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TimeoutEn  = (TIMEOUT_CYCLES != 0);
    localparam logic [TimerWidth-1:0] TimerLast =
        (TIMEOUT_CYCLES == 0) ? '0 : TimerWidth'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  RespSlvErr = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StAddrData,
        StWaitB,
        StResp
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;
    logic                    awvalid_q;
    logic                    wvalid_q;
    logic                    bready_q;
    logic                    rsp_valid_q;
    logic [1:0]              rsp_resp_q;
    logic                    rsp_timeout_q;
    logic [TimerWidth-1:0]   timer_q;
    logic [CNT_WIDTH-1:0]    wr_cnt_q;
    logic [CNT_WIDTH-1:0]    err_cnt_q;

    logic b_hs;
    logic timeout_hit;
    logic aw_done;
    logic w_done;
    logic enter_resp;
    logic resp_is_err;

    // Handshake and transition conditions shared by the FSM and the counters.
    always_comb begin
        b_hs        = bvalid_i && bready_q;
        // A B handshake on the final cycle takes priority over the timeout.
        timeout_hit = TimeoutEn && !bvalid_i && (timer_q == TimerLast);
        aw_done     = !awvalid_q || awready_i;
        w_done      = !wvalid_q || wready_i;
        enter_resp  = (state_q == StWaitB) && (b_hs || timeout_hit);
        resp_is_err = b_hs ? (bresp_i != 2'b00) : 1'b1;
    end

    // Transaction FSM with registered AXI and response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
            timer_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid_i) begin
                        awaddr_q  <= cmd_addr_i;
                        wdata_q   <= cmd_data_i;
                        wstrb_q   <= cmd_strb_i;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= StAddrData;
                    end
                end
                StAddrData: begin
                    if (awready_i) begin
                        awvalid_q <= 1'b0;
                    end
                    if (wready_i) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        timer_q  <= '0;
                        state_q  <= StWaitB;
                    end
                end
                StWaitB: begin
                    if (b_hs) begin
                        rsp_resp_q    <= bresp_i;
                        rsp_timeout_q <= 1'b0;
                        bready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= StResp;
                    end else if (timeout_hit) begin
                        rsp_resp_q    <= RespSlvErr;
                        rsp_timeout_q <= 1'b1;
                        bready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= StResp;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Saturating completion and error counters, bumped on entry to RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (enter_resp) begin
            if (wr_cnt_q != '1) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
            if (resp_is_err && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign cmd_ready_o   = (state_q == StIdle);
    assign busy_o        = (state_q != StIdle);
    assign awaddr_o      = awaddr_q;
    assign awvalid_o     = awvalid_q;
    assign wdata_o       = wdata_q;
    assign wstrb_o       = wstrb_q;
    assign wvalid_o      = wvalid_q;
    assign bready_o      = bready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_resp_o    = rsp_resp_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign wr_cnt_o      = wr_cnt_q;
    assign err_cnt_o     = err_cnt_q;

endmodule
